umi_switch_fifo: RTL and testbench

Next-generation pipelined UMI crossbar with N inputs and M outputs. Each output has its own arbiter and DEPTH-entry output FIFO, so a stalled output never blocks traffic to other outputs. Arbitration per output is fixed-priority or round-robin. A grant is locked across a multi-transfer packet until the EOM transfer. The block sits between UMI request sources and endpoint/router ports, in place of the unbuffered switch.

---
 rtl/umi_switch_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_umi_switch_fifo.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_switch_fifo.sv
// umi_switch_fifo
// ---------------
// Buffered UMI crossbar with N request inputs and M outputs. Each output has
// its own arbiter and a DEPTH-entry FIFO. A full or stalled output therefore
// never holds up traffic that is headed to a different output.
//
// Routing: input j targets the lowest output k whose request bit
// [k*N+j] is set. Input j is eligible at output k when it targets k and
// arbmask[k*N+j] is clear.
//
// Arbitration: each output picks one winner per cycle, using fixed priority
// (arbmode=0) or round-robin (any other arbmode). A multi-transfer packet
// locks the output to its sender until the transfer that carries EOM.
//
// Ports:
//   clk, nreset        clock, asynchronous active-low reset
//   arbmode[1:0]       0 = fixed priority, otherwise round-robin
//   arbmask[N*M]       1 = path disabled, bit [k*N+j] = input j -> output k
//   umi_in_request     per-input one-hot target request, bit [k*N+j]
//   umi_in_cmd/dstaddr/srcaddr/data   per-input payload
//   umi_in_ready[N]    per-input accept
//   umi_out_valid[M]   per-output FIFO not empty
//   umi_out_cmd/dstaddr/srcaddr/data  per-output FIFO head, zero when idle
//   umi_out_ready[M]   per-output pop
module umi_switch_fifo #(
  parameter int DW    = 256,
  parameter int CW    = 32,
  parameter int AW    = 64,
  parameter int N     = 3,
  parameter int M     = 6,
  parameter int DEPTH = 4,
  parameter int EOMB  = 22
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [1:0]      arbmode,
  input  logic [N*M-1:0]  arbmask,
  input  logic [N*M-1:0]  umi_in_request,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic [M-1:0]    umi_out_valid,
  output logic [M*CW-1:0] umi_out_cmd,
  output logic [M*AW-1:0] umi_out_dstaddr,
  output logic [M*AW-1:0] umi_out_srcaddr,
  output logic [M*DW-1:0] umi_out_data,
  input  logic [M-1:0]    umi_out_ready
);

  localparam int NW     = (N > 1) ? $clog2(N) : 1;
  localparam int MW     = (M > 1) ? $clog2(M) : 1;
  localparam int PW     = $clog2(DEPTH);
  localparam int CNTW   = $clog2(DEPTH + 1);
  localparam int EW     = CW + 2 * AW + DW;
  // A FIFO entry is packed as {cmd, dstaddr, srcaddr, data}.
  localparam int EOMPOS = 2 * AW + DW + EOMB;

  logic [EW-1:0]   w_inEntry [N];
  logic [N-1:0]    w_tgtValid;
  logic [MW-1:0]   w_tgt [N];
  logic [N-1:0]    w_hit [M];
  logic [N-1:0]    w_elig [M];
  logic [M-1:0]    w_winValid;
  logic [NW-1:0]   w_winner [M];
  logic [M-1:0]    w_full;
  logic [M-1:0]    w_push;
  logic [M-1:0]    w_pop;
  logic [M-1:0]    w_pushEom;
  logic [EW-1:0]   w_pushEntry [M];
  logic [EW-1:0]   w_head [M];

  logic [PW-1:0]   r_wrPtr [M];
  logic [PW-1:0]   r_rdPtr [M];
  logic [CNTW-1:0] r_count [M];
  logic [M-1:0]    r_lockValid;
  logic [NW-1:0]   r_lockOwner [M];
  logic [NW-1:0]   r_rrPtr [M];
  logic [EW-1:0]   r_mem [M][DEPTH];

  // Pack each input's payload and find its target. The loop runs from the
  // highest output down, so the lowest set request bit wins. Any extra
  // request bits are ignored.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_inEntry[j]  = {umi_in_cmd[j*CW +: CW], umi_in_dstaddr[j*AW +: AW],
                       umi_in_srcaddr[j*AW +: AW], umi_in_data[j*DW +: DW]};
      w_tgtValid[j] = 1'b0;
      w_tgt[j]      = '0;
      for (int k = M - 1; k >= 0; k--) begin
        if (umi_in_request[k*N+j]) begin
          w_tgtValid[j] = 1'b1;
          w_tgt[j]      = MW'(k);
        end
      end
    end
  end

  // w_hit ignores the mask, because a packet that is already locked keeps
  // going even if its path is masked later. w_elig is the masked view that
  // new arbitration uses.
  always_comb begin
    for (int k = 0; k < M; k++) begin
      for (int j = 0; j < N; j++) begin
        w_hit[k][j]  = w_tgtValid[j] && (w_tgt[j] == MW'(k));
        w_elig[k][j] = w_hit[k][j] && !arbmask[k*N+j];
      end
    end
  end

  // Per-output arbiter. Each search walks downward, so the last match it
  // records is the lowest index, or the first index at/after the RR pointer.
  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k < M; k++) begin
      w_winValid[k] = 1'b0;
      w_winner[k]   = '0;
      if (r_lockValid[k]) begin
        if (w_hit[k][r_lockOwner[k]]) begin
          w_winValid[k] = 1'b1;
          w_winner[k]   = r_lockOwner[k];
        end
      end else if (arbmode == 2'd0) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (w_elig[k][NW'(i)]) begin
            w_winValid[k] = 1'b1;
            w_winner[k]   = NW'(i);
          end
        end
      end else begin
        for (int i = N - 1; i >= 0; i--) begin
          idx = int'(r_rrPtr[k]) + i;
          if (idx >= N) idx = idx - N;
          if (w_elig[k][NW'(idx)]) begin
            w_winValid[k] = 1'b1;
            w_winner[k]   = NW'(idx);
          end
        end
      end
    end
  end

  // Push and pop decisions. Fullness uses the registered count only, so a
  // full FIFO refuses a push even when the same cycle pops it.
  always_comb begin
    for (int k = 0; k < M; k++) begin
      w_full[k]      = (r_count[k] == CNTW'(DEPTH));
      w_push[k]      = nreset && w_winValid[k] && !w_full[k];
      w_pushEntry[k] = w_inEntry[w_winner[k]];
      w_pushEom[k]   = w_pushEntry[k][EOMPOS];
      w_pop[k]       = (r_count[k] != '0) && umi_out_ready[k];
    end
  end

  // Each input can win at most its one target output, so OR-ing the grants
  // gives its ready.
  always_comb begin
    umi_in_ready = '0;
    for (int k = 0; k < M; k++) begin
      for (int j = 0; j < N; j++) begin
        if (w_push[k] && (w_winner[k] == NW'(j))) umi_in_ready[j] = 1'b1;
      end
    end
  end

  // FIFO pointers, occupancy, packet locks and round-robin pointers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int k = 0; k < M; k++) begin
        r_wrPtr[k]     <= '0;
        r_rdPtr[k]     <= '0;
        r_count[k]     <= '0;
        r_lockValid[k] <= 1'b0;
        r_lockOwner[k] <= '0;
        r_rrPtr[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < M; k++) begin
        if (w_push[k]) begin
          r_wrPtr[k] <= r_wrPtr[k] + PW'(1);
          if (w_pushEom[k]) begin
            r_lockValid[k] <= 1'b0;
            r_rrPtr[k]     <= (w_winner[k] == NW'(N - 1)) ? '0 : w_winner[k] + NW'(1);
          end else begin
            r_lockValid[k] <= 1'b1;
            r_lockOwner[k] <= w_winner[k];
          end
        end
        if (w_pop[k]) r_rdPtr[k] <= r_rdPtr[k] + PW'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CNTW'(1);
          2'b01:   r_count[k] <= r_count[k] - CNTW'(1);
          default: r_count[k] <= r_count[k];
        endcase
      end
    end
  end

  // FIFO storage needs no reset, because occupancy alone decides whether
  // its contents are visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < M; k++) begin
      if (w_push[k]) r_mem[k][r_wrPtr[k]] <= w_pushEntry[k];
    end
  end

  // Output side. The payload is zeroed whenever the output is not valid.
  always_comb begin
    umi_out_valid   = '0;
    umi_out_cmd     = '0;
    umi_out_dstaddr = '0;
    umi_out_srcaddr = '0;
    umi_out_data    = '0;
    for (int k = 0; k < M; k++) begin
      umi_out_valid[k] = (r_count[k] != '0);
      w_head[k]        = umi_out_valid[k] ? r_mem[k][r_rdPtr[k]] : '0;
      umi_out_cmd[k*CW +: CW]     = w_head[k][EW-1 -: CW];
      umi_out_dstaddr[k*AW +: AW] = w_head[k][2*AW+DW-1 -: AW];
      umi_out_srcaddr[k*AW +: AW] = w_head[k][AW+DW-1 -: AW];
      umi_out_data[k*DW +: DW]    = w_head[k][DW-1:0];
    end
  end

endmodule

// File: tb/tb_umi_switch_fifo.sv
// tb_umi_switch_fifo
// ------------------
// Random traffic bench for umi_switch_fifo. The driver generates packets of
// 1..3 transfers per input. It models arbitration from the routing rules,
// predicts umi_in_ready, and queues every granted transfer for its output.
// The monitor compares readies, valids and output heads against those
// predictions on the falling edge.
module tb_umi_switch_fifo;

  localparam int DW     = 256;
  localparam int CW     = 32;
  localparam int AW     = 64;
  localparam int N      = 3;
  localparam int M      = 6;
  localparam int DEPTH  = 4;
  localparam int EOMB   = 22;
  localparam int EW     = CW + 2 * AW + DW;
  localparam int EOMPOS = EW - CW + EOMB;

  typedef logic [EW-1:0] entry_t;

  logic            clk;
  logic            nreset;
  logic [1:0]      arbmode;
  logic [N*M-1:0]  arbmask;
  logic [N*M-1:0]  umi_in_request;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic [M-1:0]    umi_out_valid;
  logic [M*CW-1:0] umi_out_cmd;
  logic [M*AW-1:0] umi_out_dstaddr;
  logic [M*AW-1:0] umi_out_srcaddr;
  logic [M*DW-1:0] umi_out_data;
  logic [M-1:0]    umi_out_ready;

  umi_switch_fifo #(.DW(DW), .CW(CW), .AW(AW), .N(N), .M(M), .DEPTH(DEPTH), .EOMB(EOMB)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .arbmode         (arbmode),
    .arbmask         (arbmask),
    .umi_in_request  (umi_in_request),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: the driver only pushes, and the monitor advances headIdx.
  entry_t       expQ [M][$];
  int           headIdx [M];
  int           lockOwner [M];
  int           rrPtr [M];
  int           expGrant [M];
  logic [N-1:0] expRdyVec;

  // Per-input packet generator state.
  int           pktTgt [N];
  int           pktLeft [N];
  int           pktSent [N];
  entry_t       curEntry [N];

  logic [N*M-1:0] phaseMask;
  logic [1:0]     phaseMode;
  int             readyPct;
  bit             allowNew;
  bit             finalReq;
  bit             finalDone;
  int             checks;
  int             errors;

  function automatic entry_t randEntry();
    entry_t e;
    e = '0;
    for (int w = 0; w < (EW + 31) / 32; w++) e = (e << 32) | entry_t'($urandom);
    return e;
  endfunction

  function automatic int targetOf(input int j);
    int t;
    t = -1;
    for (int k = M - 1; k >= 0; k--) if (umi_in_request[k*N+j]) t = k;
    return t;
  endfunction

  // Winner of output k. A lock owner wins whenever it requests k. Otherwise
  // the winner is the eligible input with the smallest distance from the
  // start point: 0 in fixed mode, the RR pointer in round-robin mode.
  function automatic int pickWinner(input int k);
    int best;
    int bestKey;
    int key;
    best    = -1;
    bestKey = 0;
    if (lockOwner[k] >= 0) return (targetOf(lockOwner[k]) == k) ? lockOwner[k] : -1;
    for (int j = 0; j < N; j++) begin
      if (targetOf(j) == k && !arbmask[k*N+j]) begin
        key = (arbmode == 2'd0) ? j : (j - rrPtr[k] + N) % N;
        if (best < 0 || key < bestKey) begin
          best    = j;
          bestKey = key;
        end
      end
    end
    return best;
  endfunction

  task automatic applyStimulus();
    int extra;
    arbmode        = phaseMode;
    arbmask        = phaseMask;
    umi_in_request = '0;
    for (int j = 0; j < N; j++) begin
      if (pktLeft[j] == 0 && allowNew && $urandom_range(0, 3) == 0) begin
        pktTgt[j]  = int'($urandom_range(0, M - 1));
        pktLeft[j] = int'($urandom_range(1, 3));
        pktSent[j] = 0;
      end
      curEntry[j]         = randEntry();
      curEntry[j][EOMPOS] = (pktLeft[j] == 1);
      if (pktLeft[j] > 0 && $urandom_range(0, 9) != 0) begin
        umi_in_request[pktTgt[j]*N+j] = 1'b1;
        if (pktTgt[j] < M - 1 && $urandom_range(0, 7) == 0) begin
          extra = int'($urandom_range(pktTgt[j] + 1, M - 1));
          umi_in_request[extra*N+j] = 1'b1;
        end
      end
      umi_in_cmd[j*CW +: CW]     = curEntry[j][EW-1 -: CW];
      umi_in_dstaddr[j*AW +: AW] = curEntry[j][2*AW+DW-1 -: AW];
      umi_in_srcaddr[j*AW +: AW] = curEntry[j][AW+DW-1 -: AW];
      umi_in_data[j*DW +: DW]    = curEntry[j][DW-1:0];
    end
    for (int k = 0; k < M; k++) umi_out_ready[k] = (int'($urandom_range(1, 100)) <= readyPct);
  endtask

  task automatic predictGrants();
    int w;
    expRdyVec = '0;
    for (int k = 0; k < M; k++) begin
      expGrant[k] = -1;
      if (nreset) begin
        w = pickWinner(k);
        if (w >= 0 && (expQ[k].size() - headIdx[k]) < DEPTH) begin
          expGrant[k]  = w;
          expRdyVec[w] = 1'b1;
        end
      end
    end
  endtask

  task automatic commitGrants();
    int w;
    for (int k = 0; k < M; k++) begin
      w = expGrant[k];
      if (w >= 0) begin
        expQ[k].push_back(curEntry[w]);
        if (curEntry[w][EOMPOS]) begin
          lockOwner[k] = -1;
          rrPtr[k]     = (w + 1) % N;
        end else begin
          lockOwner[k] = w;
        end
        pktLeft[w]--;
        pktSent[w]++;
      end
      expGrant[k] = -1;
    end
  endtask

  // One clock cycle. Grants are committed at the edge. Inputs change at +2
  // and the prediction is made at +4. An optional reset is asserted at +3,
  // between edges; an optional release happens at +1.
  task automatic stepCycle(input bit doAssert, input bit doRelease);
    @(posedge clk);
    commitGrants();
    if (!allowNew) begin
      for (int j = 0; j < N; j++) if (pktSent[j] == 0) pktLeft[j] = 0;
    end
    #1;
    if (doRelease) nreset = 1'b1;
    #1;
    applyStimulus();
    #1;
    if (doAssert) begin
      nreset = 1'b0;
      for (int k = 0; k < M; k++) begin
        lockOwner[k] = -1;
        rrPtr[k]     = 0;
      end
    end
    #1;
    predictGrants();
  endtask

  function automatic bit allIdle();
    for (int j = 0; j < N; j++) if (pktLeft[j] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic checkOutput();
    entry_t       dutE;
    entry_t       expE;
    logic [M-1:0] expValid;
    if (!nreset) begin
      for (int k = 0; k < M; k++) headIdx[k] = expQ[k].size();
    end
    checks++;
    if (umi_in_ready !== expRdyVec) begin
      errors++;
      $display("[TB] FAIL in_ready at %0t: got %b expected %b", $time, umi_in_ready, expRdyVec);
    end
    for (int k = 0; k < M; k++) expValid[k] = (expQ[k].size() > headIdx[k]);
    checks++;
    if (umi_out_valid !== expValid) begin
      errors++;
      $display("[TB] FAIL out_valid at %0t: got %b expected %b", $time, umi_out_valid, expValid);
    end
    for (int k = 0; k < M; k++) begin
      dutE = {umi_out_cmd[k*CW +: CW], umi_out_dstaddr[k*AW +: AW],
              umi_out_srcaddr[k*AW +: AW], umi_out_data[k*DW +: DW]};
      expE = expValid[k] ? expQ[k][headIdx[k]] : '0;
      checks++;
      if (dutE !== expE) begin
        errors++;
        $display("[TB] FAIL payload[%0d] at %0t: got %h expected %h", k, $time, dutE, expE);
      end
      if (expValid[k] && umi_out_ready[k]) headIdx[k]++;
    end
    if (finalReq && !finalDone) begin
      finalDone = 1'b1;
      for (int k = 0; k < M; k++) begin
        checks++;
        if (expQ[k].size() != headIdx[k]) begin
          errors++;
          $display("[TB] FAIL drain[%0d]: got %0d entries left, expected 0", k, expQ[k].size() - headIdx[k]);
        end
      end
    end
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    nreset         = 1'b1;
    arbmode        = '0;
    arbmask        = '0;
    umi_in_request = '0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = '0;
    expRdyVec      = '0;
    phaseMask      = '0;
    phaseMode      = 2'd0;
    readyPct       = 100;
    allowNew       = 1'b0;
    finalReq       = 1'b0;
    finalDone      = 1'b0;
    checks         = 0;
    errors         = 0;
    for (int k = 0; k < M; k++) begin
      headIdx[k]   = 0;
      lockOwner[k] = -1;
      rrPtr[k]     = 0;
      expGrant[k]  = -1;
    end
    for (int j = 0; j < N; j++) begin
      pktTgt[j]   = 0;
      pktLeft[j]  = 0;
      pktSent[j]  = 0;
      curEntry[j] = '0;
    end
    #1 nreset = 1'b0;
    repeat (3) stepCycle(1'b0, 1'b0);
    stepCycle(1'b0, 1'b1);

    for (int p = 0; p < 12; p++) begin
      phaseMode = (p == 0) ? 2'd0 : (p == 1) ? 2'd1 : 2'($urandom_range(0, 3));
      phaseMask = '0;
      if (p % 3 == 2) begin
        for (int b = 0; b < N * M; b++) phaseMask[b] = ($urandom_range(0, 3) == 0);
      end
      case (p % 4)
        0:       readyPct = 100;
        1:       readyPct = 70;
        2:       readyPct = 35;
        default: readyPct = 0;
      endcase
      allowNew = 1'b1;
      for (int c = 0; c < 150; c++) stepCycle(p == 5 && c == 80, p == 5 && c == 84);
      allowNew = 1'b0;
      readyPct = 100;
      for (int c = 0; c < 200 && !allIdle(); c++) stepCycle(1'b0, 1'b0);
      repeat (DEPTH + 2) stepCycle(1'b0, 1'b0);
    end

    finalReq = 1'b1;
    repeat (3) stepCycle(1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
